// File: rtl/tp_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tp_ram_arbiter                                                 |
// | Purpose : Shares both ports of a tp_ram (write port and read port)       |
// |           between two requesters. Each port has its own round-robin      |
// |           arbiter, so one write and one read can issue per cycle. Read   |
// |           data is steered back to its issuer by a latency-matched tag    |
// |           pipeline.                                                      |
// | Options : TP_RAM_ARB_INIT_EN - when defined, the RAM is zero-filled      |
// |           after every reset (INIT state, busy=1, no grants).             |
// | Ports   : clk, rst_n           clock, async active-low reset             |
// |           rN_req/we/addr/wdata request side for requester N (N=0,1)      |
// |           rN_gnt               combinational accept                      |
// |           rN_rvalid/rdata      read return for requester N               |
// |           ram_wr_*, ram_rd_*   to the tp_ram write / read ports          |
// |           ram_rd_data          read data from tp_ram                     |
// |           busy                 initialisation in progress                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tp_ram_arbiter #(
  parameter int DEPTH        = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 3,
  parameter int ADDR_WIDTH   = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  // requester 1
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  // tp_ram side
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  // status
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_init_wr;
  logic   w_run;

`ifdef TP_RAM_ARB_INIT_EN
  localparam state_t                C_RESET_STATE = ST_INIT;
  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                  w_init_done;

  assign w_init_done = (r_init_addr == C_LAST_ADDR);

  // Address of the zero-fill write issued this cycle while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init_addr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= w_init_done ? '0 : r_init_addr + 1'b1;
    end
  end
`else
  localparam state_t C_RESET_STATE = ST_RUN;
`endif

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_wr   = 1'b0;
    unique case (r_state)
      ST_INIT: begin
`ifdef TP_RAM_ARB_INIT_EN
        // Gated by rst_n so the RAM sees no write while reset is held.
        w_init_wr = rst_n;
        if (w_init_done) begin
          w_state_nxt = ST_RUN;
        end
`else
        w_state_nxt = ST_RUN;
`endif
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // Grants are combinational, so they must be forced low while reset is held.
  assign w_run = rst_n & (r_state == ST_RUN);

`ifdef TP_RAM_ARB_INIT_EN
  assign busy = (r_state == ST_INIT);
`else
  assign busy = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Write port arbitration
  // ---------------------------------------------------------------------
  logic                  r_wr_last;   // last write winner
  logic                  w_wc0, w_wc1;
  logic                  w_wr_gnt;
  logic                  w_wr_sel;
  logic [ADDR_WIDTH-1:0] w_wr_addr_arb;
  logic [DATA_WIDTH-1:0] w_wr_data_arb;

  assign w_wc0    = w_run & r0_req & r0_we;
  assign w_wc1    = w_run & r1_req & r1_we;
  assign w_wr_gnt = w_wc0 | w_wc1;
  // Requester 1 wins when alone, or when both compete and 0 won last time.
  assign w_wr_sel = w_wc1 & (~w_wc0 | ~r_wr_last);

  assign w_wr_addr_arb = w_wr_sel ? r1_addr  : r0_addr;
  assign w_wr_data_arb = w_wr_sel ? r1_wdata : r0_wdata;

  // ---------------------------------------------------------------------
  // Read port arbitration
  // ---------------------------------------------------------------------
  logic r_rd_last;   // last read winner
  logic w_rc0, w_rc1;
  logic w_rd_gnt;
  logic w_rd_sel;

  // A read hitting the address being written this cycle is held back one
  // cycle so that it always returns the post-write data.
  assign w_rc0 = w_run & r0_req & ~r0_we & ~(w_wr_gnt & (r0_addr == w_wr_addr_arb));
  assign w_rc1 = w_run & r1_req & ~r1_we & ~(w_wr_gnt & (r1_addr == w_wr_addr_arb));

  assign w_rd_gnt = w_rc0 | w_rc1;
  assign w_rd_sel = w_rc1 & (~w_rc0 | ~r_rd_last);

  // Pointers reset to "requester 1 won last" so requester 0 is preferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_last <= 1'b1;
      r_rd_last <= 1'b1;
    end else begin
      if (w_wr_gnt) begin
        r_wr_last <= w_wr_sel;
      end
      if (w_rd_gnt) begin
        r_rd_last <= w_rd_sel;
      end
    end
  end

  assign r0_gnt = (w_wr_gnt & ~w_wr_sel) | (w_rd_gnt & ~w_rd_sel);
  assign r1_gnt = (w_wr_gnt &  w_wr_sel) | (w_rd_gnt &  w_rd_sel);

  // ---------------------------------------------------------------------
  // RAM-side muxing
  // ---------------------------------------------------------------------
  always_comb begin
    ram_wr_en   = w_wr_gnt;
    ram_wr_addr = w_wr_addr_arb;
    ram_wr_data = w_wr_data_arb;
`ifdef TP_RAM_ARB_INIT_EN
    if (w_init_wr) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = r_init_addr;
      ram_wr_data = '0;
    end
`else
    if (w_init_wr) begin
      ram_wr_en = 1'b1;
    end
`endif
  end

  assign ram_rd_en   = w_rd_gnt;
  assign ram_rd_addr = w_rd_sel ? r1_addr : r0_addr;

  // ---------------------------------------------------------------------
  // Tag pipeline: one {valid,id} stage per cycle of RAM read latency
  // ---------------------------------------------------------------------
  logic [READ_LATENCY-1:0] r_tag_v;
  logic [READ_LATENCY-1:0] r_tag_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_rd_gnt;
      r_tag_id[0] <= w_rd_sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  assign r0_rvalid = r_tag_v[READ_LATENCY-1] & ~r_tag_id[READ_LATENCY-1];
  assign r1_rvalid = r_tag_v[READ_LATENCY-1] &  r_tag_id[READ_LATENCY-1];
  assign r0_rdata  = ram_rd_data;
  assign r1_rdata  = ram_rd_data;

endmodule
`default_nettype wire
